decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  Decode/issue stage placed directly upstream of regfile. Takes 32-bit MIPS instructions
//  from fetch over a valid/ready handshake and drives the regfile read/write addresses.
//  It passes ALU control and the immediate downstream. A 32-entry busy scoreboard holds
//  back any instruction whose source register has a write still in flight.
//  The scoreboard is cleared by the writeback port.
// PARAMETERS
//  NREGS   32  architectural registers; address width is 5 bits. Not to be changed.
//  XLEN    32  instruction and immediate width.
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  in_valid       in   1   fetch presents in_instr
//  in_ready       out  1   stage accepts in_instr this cycle
//  in_instr       in   32  MIPS instruction word
//  out_valid      out  1   decoded instruction held on outputs
//  out_ready      in   1   downstream consumes the decoded instruction
//  ReadRegister1  out  5   rs; goes to regfile
//  ReadRegister2  out  5   rt; goes to regfile
//  WriteRegister  out  5   destination: rd (R-type), rt (I-type), 31 (jal)
//  RegWrite       out  1   instruction writes WriteRegister
//  out_alu_op     out  3   ALU_* code from package
//  out_imm        out  32  sign-extended imm16; zero-extended for andi/ori
//  out_illegal    out  1   unknown opcode/funct; RegWrite forced to 0
//  wb_valid       in   1   writeback retires a register write
//  wb_reg         in   5   register being retired
// BEHAVIOUR
//  - Reset: out_valid=0, all outputs 0, busy[31:0]=0, in_ready=0 while reset is high.
//  - Output register is one entry. Accept = in_valid & in_ready. Outputs appear the next
//    cycle with out_valid=1 (latency 1). Outputs hold while out_valid & !out_ready.
//  - in_ready = !reset & (!out_valid | out_ready) & !hazard.
//  - hazard = a source of in_instr (rs always; rt for R-type, beq, bne, sw) is busy, or
//    equals the held entry's WriteRegister while that entry has out_valid & RegWrite.
//  - Register 0 never creates a hazard and is never marked busy.
//  - Issue = out_valid & out_ready. On issue with RegWrite & WriteRegister!=0, set busy.
//  - wb_valid clears busy[wb_reg]. If set and clear hit the same register in one cycle,
//    set wins, because the newer writer is still pending.
//  - No same-cycle bypass: a clear is visible to the hazard check one cycle later.
//  - Decode:
//      op=0, funct add/sub/and/or/xor/slt -> RegWrite=1.
//      addi, andi, ori, slti, lw -> RegWrite=1.
//      sw, beq, bne, j -> RegWrite=0.
//      jal -> WriteRegister=31, RegWrite=1.
//      Anything else -> out_illegal=1, RegWrite=0.
//  - beq/bne: ALU_SUB. lw/sw: ALU_ADD.
//  - Back-to-back issue at one instruction per cycle when there is no hazard and out_ready=1.
//  - Reset mid-operation drops the held entry and clears the whole scoreboard.
// STRUCTURE
//  - Package mips_isa_pkg holds:
//      OP_* opcodes and FN_* funct constants
//      ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLT=5
//      REG_RA=31
//  - Sub-module regfile_scoreboard (busy vector with set/clear ports and two query ports).
//  - Decode is combinational logic feeding the output register.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy=0.
//  2 add $3,$1,$2 (0x00221820), out_ready=1 ->
//      next cycle: ReadRegister1=1, ReadRegister2=2, WriteRegister=3, RegWrite=1, ALU_ADD.
//  3 RAW hazard: add $3,.. then sub $4,$3,$5 -> in_ready=0 until wb_valid with wb_reg=3;
//      the sub is accepted 1 cycle after the clear.
//  4 Simultaneous events: issue of a $7 writer in the same cycle as wb_valid, wb_reg=7 ->
//      busy[7]=1 afterwards.
//  5 Immediates:
//      addi $8,$0,-1 (0x2008FFFF) -> out_imm=0xFFFFFFFF, WriteRegister=8.
//      ori -> zero-extended immediate.
//      jal -> WriteRegister=31.
//      opcode 0x3F -> out_illegal=1, RegWrite=0.
//  6 Backpressure: out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//      Then out_ready=1 -> one issue per cycle.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, ALU codes and the combinational instruction decoder
// shared by the decode/issue stage and its bench.
package mips_isa_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } aluOp_e;

  typedef struct packed {
    logic [REG_W-1:0] rr1;
    logic [REG_W-1:0] rr2;
    logic [REG_W-1:0] wr;
    logic             regWrite;
    aluOp_e           aluOp;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } decoded_t;

  function automatic decoded_t decode(input logic [XLEN-1:0] instr);
    decoded_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op         = instr[31:26];
    fn         = instr[5:0];
    d.rr1      = instr[25:21];
    d.rr2      = instr[20:16];
    d.wr       = instr[20:16];
    d.regWrite = 1'b0;
    d.aluOp    = ALU_ADD;
    d.imm      = {{16{instr[15]}}, instr[15:0]};
    d.illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.wr       = instr[15:11];
        d.regWrite = 1'b1;
        case (fn)
          FN_ADD:  d.aluOp = ALU_ADD;
          FN_SUB:  d.aluOp = ALU_SUB;
          FN_AND:  d.aluOp = ALU_AND;
          FN_OR:   d.aluOp = ALU_OR;
          FN_XOR:  d.aluOp = ALU_XOR;
          FN_SLT:  d.aluOp = ALU_SLT;
          default: begin
            d.illegal  = 1'b1;
            d.regWrite = 1'b0;
          end
        endcase
      end
      OP_ADDI: d.regWrite = 1'b1;
      OP_SLTI: begin
        d.regWrite = 1'b1;
        d.aluOp    = ALU_SLT;
      end
      OP_ANDI: begin
        d.regWrite = 1'b1;
        d.aluOp    = ALU_AND;
        d.imm      = {16'h0000, instr[15:0]};
      end
      OP_ORI: begin
        d.regWrite = 1'b1;
        d.aluOp    = ALU_OR;
        d.imm      = {16'h0000, instr[15:0]};
      end
      OP_LW:          d.regWrite = 1'b1;
      OP_SW:          d.regWrite = 1'b0;
      OP_BEQ, OP_BNE: d.aluOp    = ALU_SUB;
      OP_J:           d.regWrite = 1'b0;
      OP_JAL: begin
        d.wr       = REG_RA;
        d.regWrite = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // rs is always a source; rt only for formats that read it
  function automatic logic usesRt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch handshake, decoded-issue bus and writeback port of the decode/issue stage.
interface decode_issue_stage_if;
  import mips_isa_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [REG_W-1:0] ReadRegister1;
  logic [REG_W-1:0] ReadRegister2;
  logic [REG_W-1:0] WriteRegister;
  logic             RegWrite;
  logic [2:0]       out_alu_op;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic             wb_valid;
  logic [REG_W-1:0] wb_reg;

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_reg,
    input  in_ready, out_valid, ReadRegister1, ReadRegister2, WriteRegister,
           RegWrite, out_alu_op, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_reg,
    output in_ready, out_valid, ReadRegister1, ReadRegister2, WriteRegister,
           RegWrite, out_alu_op, out_imm, out_illegal
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue of a writer, cleared on writeback.
module regfile_scoreboard
  import mips_isa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             setValid,
  input  logic [REG_W-1:0] setReg,
  input  logic             clrValid,
  input  logic [REG_W-1:0] clrReg,
  input  logic [REG_W-1:0] q1Reg,
  output logic             q1Busy,
  input  logic [REG_W-1:0] q2Reg,
  output logic             q2Busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;

  // set applied after clear: a newer writer to the same register stays pending
  always_comb begin
    busyNext = busy;
    if (clrValid) busyNext[clrReg] = 1'b0;
    if (setValid && (setReg != '0)) busyNext[setReg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end

  assign q1Busy = busy[q1Reg];
  assign q2Busy = busy[q2Reg];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one-entry output register, RAW hazard stall against the
// busy scoreboard and the held (not yet issued) entry.
module decode_issue_stage
  import mips_isa_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  decode_issue_stage_if.slave bus
);

  decoded_t         dec;
  decoded_t         held;
  logic             outValid;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             q1Busy;
  logic             q2Busy;
  logic             hz1;
  logic             hz2;
  logic             inReady;
  logic             accept;
  logic             issue;

  assign rs = bus.in_instr[25:21];
  assign rt = bus.in_instr[20:16];

  always_comb dec = decode(bus.in_instr);

  regfile_scoreboard scoreboard (
    .clk      (clk),
    .reset    (reset),
    .setValid (issue & held.regWrite),
    .setReg   (held.wr),
    .clrValid (bus.wb_valid),
    .clrReg   (bus.wb_reg),
    .q1Reg    (rs),
    .q1Busy   (q1Busy),
    .q2Reg    (rt),
    .q2Busy   (q2Busy)
  );

  // the held entry is not in the scoreboard until it issues, so check it directly
  always_comb begin
    hz1 = (rs != '0) && (q1Busy || (outValid && held.regWrite && (held.wr == rs)));
    hz2 = usesRt(bus.in_instr[31:26]) && (rt != '0) &&
          (q2Busy || (outValid && held.regWrite && (held.wr == rt)));
  end

  assign inReady = !reset && (!outValid || bus.out_ready) && !(hz1 || hz2);
  assign accept  = bus.in_valid && inReady;
  assign issue   = outValid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      held     <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      held     <= dec;
    end else if (issue) begin
      outValid <= 1'b0;
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.out_valid     = outValid;
  assign bus.ReadRegister1 = held.rr1;
  assign bus.ReadRegister2 = held.rr2;
  assign bus.WriteRegister = held.wr;
  assign bus.RegWrite      = held.regWrite;
  assign bus.out_alu_op    = held.aluOp;
  assign bus.out_imm       = held.imm;
  assign bus.out_illegal   = held.illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: decode table plus hazard, writeback,
// backpressure and reset sequences.
module tb_decode_issue_stage;
  import mips_isa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  decode_issue_stage_if bus ();

  decode_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic        rw;
    aluOp_e      alu;
    logic [31:0] imm;
    logic        ill;
    logic        chkWr;
    logic        chkAluImm;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"add",   32'h00221820, 5'd1,  5'd2,  5'd3,  1'b1, ALU_ADD, 32'h00001820, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{"sub",   32'h00652022, 5'd3,  5'd5,  5'd4,  1'b1, ALU_SUB, 32'h00002022, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"xor",   32'h014B4826, 5'd10, 5'd11, 5'd9,  1'b1, ALU_XOR, 32'h00004826, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{"slt",   32'h01AE602A, 5'd13, 5'd14, 5'd12, 1'b1, ALU_SLT, 32'h0000602A, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{"addi",  32'h2008FFFF, 5'd0,  5'd8,  5'd8,  1'b1, ALU_ADD, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"ori",   32'h34268001, 5'd1,  5'd6,  5'd6,  1'b1, ALU_OR,  32'h00008001, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{"andi",  32'h3047F0F0, 5'd2,  5'd7,  5'd7,  1'b1, ALU_AND, 32'h0000F0F0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{"slti",  32'h2825FFFE, 5'd1,  5'd5,  5'd5,  1'b1, ALU_SLT, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{"lw",    32'h8FAAFFFC, 5'd29, 5'd10, 5'd10, 1'b1, ALU_ADD, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"sw",    32'hAFAB0008, 5'd29, 5'd11, 5'd11, 1'b0, ALU_ADD, 32'h00000008, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"beq",   32'h1022FFFF, 5'd1,  5'd2,  5'd2,  1'b0, ALU_SUB, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{"bne",   32'h14640010, 5'd3,  5'd4,  5'd4,  1'b0, ALU_SUB, 32'h00000010, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{"jal",   32'h0C000100, 5'd0,  5'd0,  5'd31, 1'b1, ALU_ADD, 32'h00000100, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{"j",     32'h08000100, 5'd0,  5'd0,  5'd0,  1'b0, ALU_ADD, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"badop", 32'hFC221820, 5'd1,  5'd2,  5'd2,  1'b0, ALU_ADD, 32'h00001820, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{"badfn", 32'h0022183F, 5'd1,  5'd2,  5'd3,  1'b0, ALU_ADD, 32'h0000183F, 1'b1, 1'b0, 1'b0};

    // reset held two cycles with fetch already offering an instruction
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00221820;
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_reg    = 5'd0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", dut.scoreboard.busy, 32'd0);
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    chk("rst_wr", 32'(bus.WriteRegister), 32'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;

    // decode table: accept, check held outputs, issue, retire destination
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      #1;
      chk({vecs[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk({vecs[i].name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({vecs[i].name, "_rr1"}, 32'(bus.ReadRegister1), 32'(vecs[i].rr1));
      chk({vecs[i].name, "_rr2"}, 32'(bus.ReadRegister2), 32'(vecs[i].rr2));
      chk({vecs[i].name, "_regwrite"}, 32'(bus.RegWrite), 32'(vecs[i].rw));
      chk({vecs[i].name, "_illegal"}, 32'(bus.out_illegal), 32'(vecs[i].ill));
      if (vecs[i].chkWr)
        chk({vecs[i].name, "_wr"}, 32'(bus.WriteRegister), 32'(vecs[i].wr));
      if (vecs[i].chkAluImm) begin
        chk({vecs[i].name, "_alu"}, 32'(bus.out_alu_op), 32'(vecs[i].alu));
        chk({vecs[i].name, "_imm"}, bus.out_imm, vecs[i].imm);
      end
      tick();
      #1;
      chk({vecs[i].name, "_issued"}, 32'(bus.out_valid), 32'd0);
      bus.wb_valid = 1'b1;
      bus.wb_reg   = vecs[i].wr;
      tick();
      bus.wb_valid = 1'b0;
    end

    // RAW: sub $4,$3,$5 behind add $3
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00221820;
    tick();
    bus.in_instr = 32'h00652022;
    #1;
    chk("raw_held_hazard", 32'(bus.in_ready), 32'd0);
    tick();
    #1;
    chk("raw_not_accepted", 32'(bus.out_valid), 32'd0);
    chk("raw_busy_hazard", 32'(bus.in_ready), 32'd0);
    chk("raw_busy3", 32'(dut.scoreboard.busy[3]), 32'd1);
    tick();
    #1;
    chk("raw_still_stalled", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd3;
    #1;
    chk("raw_no_bypass", 32'(bus.in_ready), 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("raw_ready_after_clear", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("raw_sub_valid", 32'(bus.out_valid), 32'd1);
    chk("raw_sub_rr1", 32'(bus.ReadRegister1), 32'd3);
    chk("raw_sub_wr", 32'(bus.WriteRegister), 32'd4);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd4;
    tick();
    bus.wb_valid = 1'b0;

    // issue of a $7 writer coincides with writeback of $7
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h20070005;
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd7;
    tick();
    bus.wb_valid = 1'b0;
    bus.in_instr = 32'h00E00820;
    bus.in_valid = 1'b1;
    #1;
    chk("sim_busy7", 32'(dut.scoreboard.busy[7]), 32'd1);
    chk("sim_hazard7", 32'(bus.in_ready), 32'd0);
    bus.wb_valid = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("sim_ready_after_clear", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd1;
    tick();
    bus.wb_valid = 1'b0;

    // backpressure: add held for 3 cycles while an independent xor waits
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00221820;
    tick();
    bus.in_instr = 32'h014B4826;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_wr", 32'(bus.WriteRegister), 32'd3);
      chk("bp_imm", bus.out_imm, 32'h00001820);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_instr = 32'h34268001;
    #1;
    chk("b2b_xor_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_xor_wr", 32'(bus.WriteRegister), 32'd9);
    chk("b2b_ori_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_ori_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_ori_wr", 32'(bus.WriteRegister), 32'd6);
    chk("b2b_busy", dut.scoreboard.busy, 32'h00000208);

    // reset with an entry held and registers still busy
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", dut.scoreboard.busy, 32'd0);
    chk("midrst_regwrite", 32'(bus.RegWrite), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
